// File: rtl/alu_pkg.sv
// Shared types and constants for the mode-selectable ALU.
// Op codes, mode limits, flag bundle and the mode-step helper.
package alu_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLT = 3'd6,
    OP_EQ  = 3'd7
  } alu_op_e;

  localparam logic [MODE_W-1:0] MODE_MIN = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(7);

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

  // Saturating step; simultaneous presses cancel out.
  function automatic logic [MODE_W-1:0] next_mode(
    input logic [MODE_W-1:0] m,
    input logic              up,
    input logic              dn
  );
    next_mode = m;
    if (up && !dn && (m != MODE_MAX)) begin
      next_mode = m + MODE_W'(1);
    end else if (dn && !up && (m != MODE_MIN)) begin
      next_mode = m - MODE_W'(1);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, debouncer,
// and a one-cycle registered pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic          db_prev_q, db_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Next state: count mismatches, flip level after a full run.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    cnt_d     = '0;
    db_prev_d = db_q;
    press_d   = db_q & ~db_prev_q;
    if (sync2_q != db_q) begin
      if (cnt_q == LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_mode_unit.sv
// Button-stepped mode counter driving a one-stage registered
// ALU with carry/zero/overflow flags and a valid qualifier.
module alu_mode_unit
  import alu_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              control_up,
  input  logic              control_down,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [MODE_W-1:0] control_led,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              zero,
  output logic              overflow,
  output logic              out_valid
);

  localparam int MSB = WIDTH - 1;

  logic up_pulse;
  logic dn_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_up (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(control_up),
    .press  (up_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_dn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(control_down),
    .press  (dn_pulse)
  );

  logic [MODE_W-1:0] mode_q, mode_d;

  // Mode steps once per accepted press, saturating at both ends.
  always_comb begin
    mode_d = next_mode(mode_q, up_pulse, dn_pulse);
  end

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flg;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Combinational ALU selected by the current mode.
  always_comb begin
    alu_res          = '0;
    alu_flg.carry    = 1'b0;
    alu_flg.overflow = 1'b0;
    unique case (alu_op_e'(mode_q))
      OP_ADD: begin
        alu_res          = sum_add[MSB:0];
        alu_flg.carry    = sum_add[WIDTH];
        alu_flg.overflow = (a[MSB] == b[MSB]) &&
                           (sum_add[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res          = sum_sub[MSB:0];
        alu_flg.carry    = sum_sub[WIDTH];
        alu_flg.overflow = (a[MSB] != b[MSB]) &&
                           (sum_sub[MSB] != a[MSB]);
      end
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         ($signed(a) < $signed(b))};
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: alu_res = '0;
    endcase
    alu_flg.zero = (alu_res == '0);
  end

  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;

  // Output stage loads only on valid operands, otherwise holds.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = in_valid;
    if (in_valid) begin
      result_d = alu_res;
      flags_d  = alu_flg;
    end
  end

  // Mode and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_MIN;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign control_led = mode_q;
  assign result      = result_q;
  assign carry       = flags_q.carry;
  assign zero        = flags_q.zero;
  assign overflow    = flags_q.overflow;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_alu_mode_unit.sv
// Self-checking bench for alu_mode_unit (WIDTH=4, debounce 4).
// Directed table, mode-timing sequences and random vectors.
module tb_alu_mode_unit;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         up;
  logic         dn;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   control_led;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         out_valid;

  alu_mode_unit #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .control_up  (up),
    .control_down(dn),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .control_led (control_led),
    .result      (result),
    .carry       (carry),
    .zero        (zero),
    .overflow    (overflow),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_mode = 0;
  int er = 0;
  int ec = 0;
  int ez = 0;
  int ev = 0;

  typedef struct {
    int mode;
    int a;
    int b;
    int r;
    int c;
    int z;
    int v;
  } vec_t;

  vec_t tbl[13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_alu(input int aa, input int bb);
    int sa;
    int sb;
    int s;
    sa = (aa >= M/2) ? aa - M : aa;
    sb = (bb >= M/2) ? bb - M : bb;
    ec = 0;
    ev = 0;
    case (model_mode)
      0: begin
        s  = aa + bb;
        er = s % M;
        ec = (s >= M) ? 1 : 0;
        s  = sa + sb;
        ev = (s > M/2 - 1 || s < -M/2) ? 1 : 0;
      end
      1: begin
        er = (aa - bb + M) % M;
        ec = (aa >= bb) ? 1 : 0;
        s  = sa - sb;
        ev = (s > M/2 - 1 || s < -M/2) ? 1 : 0;
      end
      2: er = M - 1 - aa;
      3: er = aa & bb;
      4: er = aa | bb;
      5: er = aa ^ bb;
      6: er = (sa < sb) ? 1 : 0;
      default: er = (aa == bb) ? 1 : 0;
    endcase
    ez = (er == 0) ? 1 : 0;
  endtask

  task automatic drive(input string nm, input bit v,
                       input int aa, input int bb);
    in_valid = v;
    a = W'(aa);
    b = W'(bb);
    tick;
    in_valid = 1'b0;
    chk({nm, ".result"},   32'(result),    er);
    chk({nm, ".carry"},    32'(carry),     ec);
    chk({nm, ".zero"},     32'(zero),      ez);
    chk({nm, ".overflow"}, 32'(overflow),  ev);
    chk({nm, ".valid"},    32'(out_valid), 32'(v));
  endtask

  task automatic press(input bit is_up, input int hold);
    if (is_up) up = 1'b1;
    else dn = 1'b1;
    repeat (hold) tick;
    up = 1'b0;
    dn = 1'b0;
    repeat (10) tick;
    if (is_up) begin
      if (model_mode < 7) model_mode++;
    end else begin
      if (model_mode > 0) model_mode--;
    end
    chk("mode_step", 32'(control_led), model_mode);
  endtask

  task automatic set_mode(input int m);
    int guard;
    guard = 0;
    while (model_mode != m && guard < 16) begin
      press(model_mode < m, 10);
      guard++;
    end
  endtask

  initial begin
    rst = 1'b1;
    up = 1'b0;
    dn = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick;
    rst = 1'b0;
    repeat (10) tick;
    chk("rst.led",      32'(control_led), 0);
    chk("rst.result",   32'(result),      0);
    chk("rst.carry",    32'(carry),       0);
    chk("rst.zero",     32'(zero),        0);
    chk("rst.overflow", 32'(overflow),    0);
    chk("rst.valid",    32'(out_valid),   0);

    tbl[0]  = '{0, 7,  1,  8,  0, 0, 1};
    tbl[1]  = '{0, 15, 1,  0,  1, 1, 0};
    tbl[2]  = '{1, 0,  1,  15, 0, 0, 0};
    tbl[3]  = '{1, 8,  1,  7,  1, 0, 1};
    tbl[4]  = '{2, 5,  9,  10, 0, 0, 0};
    tbl[5]  = '{2, 15, 0,  0,  0, 1, 0};
    tbl[6]  = '{3, 12, 10, 8,  0, 0, 0};
    tbl[7]  = '{4, 12, 10, 14, 0, 0, 0};
    tbl[8]  = '{5, 12, 12, 0,  0, 1, 0};
    tbl[9]  = '{6, 15, 1,  1,  0, 0, 0};
    tbl[10] = '{6, 1,  15, 0,  0, 1, 0};
    tbl[11] = '{7, 5,  5,  1,  0, 0, 0};
    tbl[12] = '{7, 5,  4,  0,  0, 1, 0};

    for (int i = 0; i < 13; i++) begin
      set_mode(tbl[i].mode);
      er = tbl[i].r;
      ec = tbl[i].c;
      ez = tbl[i].z;
      ev = tbl[i].v;
      drive($sformatf("tbl%0d", i), 1'b1, tbl[i].a, tbl[i].b);
    end

    for (int m = 7; m >= 0; m--) begin
      set_mode(m);
      for (int k = 0; k < 30; k++) begin
        int aa;
        int bb;
        bit v;
        aa = int'($urandom_range(0, M - 1));
        bb = int'($urandom_range(0, M - 1));
        v  = ($urandom_range(0, 3) != 0);
        if (v) ref_alu(aa, bb);
        drive($sformatf("rnd_m%0d", m), v, aa, bb);
      end
    end

    // Press latency and mode/operand boundary, from mode 0.
    a = W'(3);
    b = W'(5);
    up = 1'b1;
    tick;
    repeat (6) tick;
    chk("lat.before", 32'(control_led), 0);
    in_valid = 1'b1;
    tick;
    ref_alu(3, 5);
    chk("lat.after",     32'(control_led), 1);
    chk("edge.old_mode", 32'(result),      er);
    chk("edge.valid",    32'(out_valid),   1);
    model_mode = 1;
    tick;
    ref_alu(3, 5);
    chk("edge.new_mode", 32'(result), er);
    chk("edge.carry",    32'(carry),  ec);
    in_valid = 1'b0;
    up = 1'b0;
    repeat (10) tick;

    for (int i = 0; i < 9; i++) press(1'b1, 10);
    chk("sat.max", 32'(control_led), 7);
    press(1'b0, 10);
    chk("sat.down", 32'(control_led), 6);

    up = 1'b1;
    dn = 1'b1;
    repeat (10) tick;
    up = 1'b0;
    dn = 1'b0;
    repeat (10) tick;
    chk("both.nochange", 32'(control_led), model_mode);

    for (int i = 0; i < 10; i++) begin
      up = ~up;
      repeat (2) tick;
    end
    up = 1'b0;
    repeat (15) tick;
    chk("bounce.nochange", 32'(control_led), model_mode);

    press(1'b1, 40);
    press(1'b0, 40);
    press(1'b1, 40);

    ref_alu(5, 5);
    drive("hold.load", 1'b1, 5, 5);
    drive("hold.idle", 1'b0, 9, 3);
    drive("hold.idle2", 1'b0, 0, 0);

    // Press held across reset: full requalification, one step.
    up = 1'b1;
    repeat (3) tick;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    model_mode = 0;
    chk("rst2.result", 32'(result),    0);
    chk("rst2.zero",   32'(zero),      0);
    chk("rst2.valid",  32'(out_valid), 0);
    repeat (7) tick;
    chk("rst2.wait", 32'(control_led), 0);
    tick;
    chk("rst2.step", 32'(control_led), 1);
    repeat (30) tick;
    chk("rst2.held", 32'(control_led), 1);
    up = 1'b0;
    repeat (10) tick;
    chk("rst2.release", 32'(control_led), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
